line_text_tx: RTL and testbench
===============================

Name: line_text_tx

Overview:
- Downstream consumer of the character-pair transformer stage.
- Collects one line of (lhs, rhs) ASCII pairs, then serialises it over a UART TX pin as: all lhs bytes, separator " = ", all rhs bytes, CR LF.
- Ends the display path: the transform table is shown as text lines, e.g. "ab = xy\r\n".

Parameters:
- DEPTH, 16: max pairs buffered per line (power of 2, 2..64).
- CLKS_PER_BIT, 16: clk cycles per UART bit (>=2).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  pair valid
- in_ready  out  1  pair accepted when in_valid & in_ready at posedge clk
- in_lhs  in  8  input-side ASCII char
- in_rhs  in  8  transformed ASCII char
- in_last  in  1  qualifies the final pair of the line
- tx  out  1  UART serial out, idle high
- busy  out  1  high in any state other than COLLECT
- overflow  out  1  sticky; line truncated at DEPTH pairs
- line_done  out  1  one-cycle pulse at end of LF stop bit

Behaviour:
- Reset values: tx=1, in_ready=1, busy=0, overflow=0, line_done=0, pair count=0, state COLLECT. Async rst mid-frame aborts immediately; tx returns high the same instant.
- Storage: two DEPTH x 8 arrays (lhs_buf, rhs_buf), write index cnt (width clog2(DEPTH)+1).
- COLLECT:
  - in_ready = (cnt < DEPTH).
  - On handshake: store both chars at cnt, cnt++.
  - If in_last, or cnt reaches DEPTH on this handshake, go to LHS next cycle.
  - The DEPTH-th pair without in_last sets overflow=1; overflow stays set until rst.
- LHS: send lhs_buf[0..cnt-1] in order, then SEP.
- SEP: send 0x20, 0x3D, 0x20, then RHS.
- RHS: send rhs_buf[0..cnt-1], then EOL.
- EOL: send 0x0D, 0x0A.
  - line_done pulses in the cycle after the last LF stop-bit cycle.
  - State returns to COLLECT, cnt=0, in_ready=1 in that same cycle.
- in_ready=0 in all states other than COLLECT; pairs presented then are held off, never dropped.
- Byte content is sent verbatim, including 0x20 padding and non-printables; no filtering.
- UART framing:
  - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit lasts exactly CLKS_PER_BIT cycles.
  - Back-to-back bytes with no idle gap: the next start bit begins on the cycle after the previous stop bit ends.
- Latency: the handshake carrying in_last at edge N drives tx low from edge N+1.
- Frame length: (2*cnt + 5) bytes x 10 x CLKS_PER_BIT cycles.
- in_last together with in_valid=0 is ignored.

Decomposition:
- Shared package (line_text_pkg):
  - ASCII constants: SEP_SP=0x20, SEP_EQ=0x3D, CR=0x0D, LF=0x0A.
  - State enum: COLLECT, LHS, SEP, RHS, EOL.
  - UART frame constant: BITS_PER_FRAME=10.
- Sub-module uart_tx_byte, parameter CLKS_PER_BIT. Ports: clk, rst, start, data[7:0], tx, done.
  - done pulses on the last stop-bit cycle.
  - start accepted on that same done cycle, which gives gapless chaining.
- Parent holds the buffers, the FSM, and the byte index/selector mux.

Test Plan:
- Two-pair line, CLKS_PER_BIT=4:
  - Stimulus: pairs (0x31,0x31), then (0x73,0x74) with in_last.
  - tx decodes 0x31,0x73,0x20,0x3D,0x20,0x31,0x74,0x0D,0x0A.
  - Total 9 x 40 = 360 cycles; line_done pulses once; in_ready=0 throughout.
- Latency:
  - tx falls exactly one cycle after the in_last handshake edge.
  - Each bit width is checked at 4 cycles; no gap between frames.
- Overflow, DEPTH=4:
  - Stimulus: 5 pairs offered, no in_last.
  - in_ready drops after the 4th; overflow=1; 4+3+4+2 = 13 bytes emitted.
  - The 5th pair is accepted only after line_done, as the first pair of the next line.
- Single-pair line:
  - Stimulus: (0x5E,0x32) with in_last.
  - Output bytes 0x5E,0x20,0x3D,0x20,0x32,0x0D,0x0A.
- Reset mid-operation:
  - Stimulus: assert rst during the 3rd data bit of byte 2.
  - tx=1 and busy=0 immediately; overflow=0.
  - The next line after release serialises correctly from its first byte.
- Backpressure:
  - Stimulus: hold in_valid=1 with varying data while busy.
  - No pair is captured until in_ready=1; captured sequence matches the offered order.

Source files
------------

// File: rtl/line_text_pkg.sv
// Shared constants, FSM encoding and separator lookup for the line text UART transmitter.
package line_text_pkg;

  localparam logic [7:0] SEP_SP = 8'h20;
  localparam logic [7:0] SEP_EQ = 8'h3D;
  localparam logic [7:0] CR     = 8'h0D;
  localparam logic [7:0] LF     = 8'h0A;

  localparam int BITS_PER_FRAME = 10;

  typedef enum logic [2:0] {
    COLLECT,
    LHS,
    SEP,
    RHS,
    EOL
  } state_t;

  // Character of " = " at position 0..2; only the middle one is '='.
  function automatic logic [7:0] sep_char(input logic [1:0] pos);
    return (pos == 2'd1) ? SEP_EQ : SEP_SP;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter; start loads on the cycle it is seen, tx drops on the next edge.
// done marks the last stop-bit cycle, and a start in that cycle chains the next frame with no gap.
module uart_tx_byte
  import line_text_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0]             r_clk_cnt;
  logic [3:0]                r_bit_idx;
  logic [BITS_PER_FRAME-1:0] r_shift;
  logic                      r_active;
  logic                      w_bit_end;
  logic                      w_load;

  assign w_bit_end = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign done      = r_active && w_bit_end && (r_bit_idx == 4'(BITS_PER_FRAME - 1));
  assign w_load    = start && (!r_active || done);
  // Idle level comes straight from r_active so an async reset forces the line high at once.
  assign tx        = r_active ? r_shift[0] : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active  <= 1'b0;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '1;
    end else if (w_load) begin
      r_active  <= 1'b1;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= {1'b1, data, 1'b0};
    end else if (r_active) begin
      if (w_bit_end) begin
        r_clk_cnt <= '0;
        if (r_bit_idx == 4'(BITS_PER_FRAME - 1)) begin
          r_active <= 1'b0;
        end else begin
          r_bit_idx <= r_bit_idx + 4'd1;
          r_shift   <= {1'b1, r_shift[BITS_PER_FRAME-1:1]};
        end
      end else begin
        r_clk_cnt <= r_clk_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/line_text_tx.sv
// Buffers one line of (lhs, rhs) pairs and sends it as "lhs = rhs\r\n" over UART, first start bit
// one edge after the closing handshake; in_ready stays low from then until line_done.
module line_text_tx
  import line_text_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_lhs,
  input  logic [7:0] in_rhs,
  input  logic       in_last,
  output logic       tx,
  output logic       busy,
  output logic       overflow,
  output logic       line_done
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DEPTH - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_idx, w_idx_nxt;
  logic             r_overflow, w_overflow_nxt;
  logic             r_line_done, w_line_done_nxt;
  logic             r_inflight, w_inflight_nxt;

  logic [7:0] r_lhs_buf [DEPTH];
  logic [7:0] r_rhs_buf [DEPTH];

  logic             w_hs;
  logic             w_start;
  logic             w_done;
  logic             w_can_start;
  logic [7:0]       w_byte;
  logic [CNT_W-1:0] w_last_idx;

  assign in_ready    = (r_state == COLLECT) && (r_cnt < CNT_W'(DEPTH));
  assign w_hs        = in_valid && in_ready;
  assign busy        = (r_state != COLLECT);
  assign overflow    = r_overflow;
  assign line_done   = r_line_done;
  assign w_last_idx  = r_cnt - CNT_W'(1);
  // A new byte may be handed over when the UART is idle or finishing its stop bit.
  assign w_can_start = !r_inflight || w_done;
  assign w_inflight_nxt = w_start ? 1'b1 : (w_done ? 1'b0 : r_inflight);

  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_lhs_buf[r_cnt[IDX_W-1:0]] <= in_lhs;
      r_rhs_buf[r_cnt[IDX_W-1:0]] <= in_rhs;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= COLLECT;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_overflow  <= 1'b0;
      r_line_done <= 1'b0;
      r_inflight  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_overflow  <= w_overflow_nxt;
      r_line_done <= w_line_done_nxt;
      r_inflight  <= w_inflight_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_overflow_nxt  = r_overflow;
    w_line_done_nxt = 1'b0;
    w_start         = 1'b0;
    w_byte          = SEP_SP;
    unique case (r_state)
      COLLECT: begin
        if (w_hs) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (in_last || r_cnt == LAST_SLOT) begin
            w_state_nxt = LHS;
            w_idx_nxt   = '0;
          end
          if (!in_last && r_cnt == LAST_SLOT) begin
            w_overflow_nxt = 1'b1;
          end
        end
      end
      LHS: begin
        w_byte = r_lhs_buf[r_idx[IDX_W-1:0]];
        if (w_can_start) begin
          w_start = 1'b1;
          if (r_idx == w_last_idx) begin
            w_state_nxt = SEP;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + CNT_W'(1);
          end
        end
      end
      SEP: begin
        w_byte = sep_char(r_idx[1:0]);
        if (w_can_start) begin
          w_start = 1'b1;
          if (r_idx == CNT_W'(2)) begin
            w_state_nxt = RHS;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + CNT_W'(1);
          end
        end
      end
      RHS: begin
        w_byte = r_rhs_buf[r_idx[IDX_W-1:0]];
        if (w_can_start) begin
          w_start = 1'b1;
          if (r_idx == w_last_idx) begin
            w_state_nxt = EOL;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + CNT_W'(1);
          end
        end
      end
      EOL: begin
        w_byte = (r_idx == '0) ? CR : LF;
        // idx 2 means LF is on the wire; the line closes when its stop bit ends.
        if (r_idx < CNT_W'(2)) begin
          if (w_can_start) begin
            w_start   = 1'b1;
            w_idx_nxt = r_idx + CNT_W'(1);
          end
        end else if (w_done) begin
          w_state_nxt     = COLLECT;
          w_cnt_nxt       = '0;
          w_idx_nxt       = '0;
          w_line_done_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = COLLECT;
      end
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk  (clk),
    .rst  (rst),
    .start(w_start),
    .data (w_byte),
    .tx   (tx),
    .done (w_done)
  );

endmodule

// File: tb/tb_line_text_tx.sv
// Bench for line_text_tx: table-driven lines, overflow, backpressure, mid-frame reset and random lines.
module tb_line_text_tx;

  localparam int CPB = 4;
  localparam int DEP = 4;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int           n;
    logic [31:0]  lhs;
    logic [31:0]  rhs;
    int           exp_len;
    logic [103:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic [7:0] in_lhs = 8'h00;
  logic [7:0] in_rhs = 8'h00;
  logic       in_ready, tx, busy, overflow, line_done;

  int errors = 0;
  int checks = 0;
  int lines_expected = 0;
  int done_pulses = 0;
  bit bp_mode = 1'b0;

  line_text_tx #(.DEPTH(DEP), .CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_lhs   (in_lhs),
    .in_rhs   (in_rhs),
    .in_last  (in_last),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow),
    .line_done(line_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (line_done === 1'b1) done_pulses++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected byte stream of a line: lhs chars, " = ", rhs chars, CR LF.
  function automatic bq_t make_line(input bq_t l, input bq_t r);
    bq_t q;
    q = l;
    q.push_back(8'h20); q.push_back(8'h3D); q.push_back(8'h20);
    foreach (r[i]) q.push_back(r[i]);
    q.push_back(8'h0D); q.push_back(8'h0A);
    return q;
  endfunction

  // Called just after a negedge; returns at the negedge following the accepting posedge.
  task automatic drive_pair(input logic [7:0] l, input logic [7:0] r, input logic last);
    int waited;
    waited = 0;
    in_valid = 1'b1; in_lhs = l; in_rhs = r; in_last = last;
    while (in_ready !== 1'b1 && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    check("handshake_within_budget", 32'(waited < 5000), 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at the negedge right after the closing handshake; checks the whole serial line.
  task automatic check_line(input bq_t eb, input string tag);
    int   nsamp, first_bad, b, j;
    bit   hold_ok;
    logic cap[$];
    logic e;
    logic [7:0] d;
    nsamp = eb.size() * 10 * CPB;
    first_bad = -1;
    hold_ok = 1'b1;
    check({tag, "_pre_tx_idle"}, 32'(tx), 1);
    check({tag, "_pre_busy"}, 32'(busy), 1);
    for (int k = 0; k < nsamp; k++) begin
      @(negedge clk);
      b = k / (10 * CPB);
      j = (k / CPB) % 10;
      e = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : eb[b][j-1];
      cap.push_back(tx);
      if (tx !== e && first_bad < 0) first_bad = k;
      if (in_ready !== 1'b0 || busy !== 1'b1 || line_done !== 1'b0) hold_ok = 1'b0;
      if (bp_mode) begin
        in_valid = 1'b1;
        in_lhs = 8'($urandom);
        in_rhs = 8'($urandom);
        in_last = 1'($urandom);
      end
    end
    check({tag, "_wave_first_bad_cycle"}, first_bad, -1);
    check({tag, "_inputs_held_off"}, 32'(hold_ok), 1);
    for (int i = 0; i < eb.size(); i++) begin
      for (int q = 0; q < 8; q++) d[q] = cap[i*10*CPB + (q+1)*CPB + CPB/2];
      check($sformatf("%s_byte%0d", tag, i), d, eb[i]);
    end
    @(negedge clk);
    check({tag, "_line_done"}, 32'(line_done), 1);
    check({tag, "_ready_after"}, 32'(in_ready), 1);
    check({tag, "_busy_after"}, 32'(busy), 0);
    lines_expected++;
  endtask

  initial begin
    vec_t tbl[4];
    bq_t  l, r, eb;
    logic [7:0] a, c;
    int n, gap;

    tbl[0] = '{n:2, lhs:32'h3173,     rhs:32'h3174,     exp_len:9,  exp:104'h3173203D2031740D0A};
    tbl[1] = '{n:1, lhs:32'h5E,       rhs:32'h32,       exp_len:7,  exp:104'h5E203D20320D0A};
    tbl[2] = '{n:4, lhs:32'h61626364, rhs:32'h7778797A, exp_len:13, exp:104'h61626364203D20777879_7A0D0A};
    tbl[3] = '{n:3, lhs:32'h2000FF,   rhs:32'h7F0A20,   exp_len:11, exp:104'h2000FF203D207F0A200D0A};

    #1;
    check("rst_tx", 32'(tx), 1);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_line_done", 32'(line_done), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[t]) begin
      eb = {};
      for (int i = 0; i < tbl[t].n; i++) begin
        a = tbl[t].lhs[(tbl[t].n-1-i)*8 +: 8];
        c = tbl[t].rhs[(tbl[t].n-1-i)*8 +: 8];
        drive_pair(a, c, i == tbl[t].n - 1);
      end
      in_valid = 1'b0; in_last = 1'b0;
      for (int k = 0; k < tbl[t].exp_len; k++) eb.push_back(tbl[t].exp[(tbl[t].exp_len-1-k)*8 +: 8]);
      check_line(eb, $sformatf("tbl%0d", t));
      check($sformatf("tbl%0d_no_overflow", t), 32'(overflow), 0);
    end

    // Overflow: four pairs without last, fifth held until the line has gone out.
    for (int i = 0; i < 4; i++) drive_pair(8'h41 + 8'(i), 8'h61 + 8'(i), 1'b0);
    check("ovf_ready_dropped", 32'(in_ready), 0);
    check("ovf_flag", 32'(overflow), 1);
    in_valid = 1'b1; in_lhs = 8'h45; in_rhs = 8'h65; in_last = 1'b0;
    check_line(make_line('{8'h41, 8'h42, 8'h43, 8'h44}, '{8'h61, 8'h62, 8'h63, 8'h64}), "ovf_line");
    drive_pair(8'h45, 8'h65, 1'b0);
    drive_pair(8'h46, 8'h66, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    check_line(make_line('{8'h45, 8'h46}, '{8'h65, 8'h66}), "ovf_next");
    check("ovf_sticky", 32'(overflow), 1);

    // Backpressure: random valid data offered all through a transmission.
    drive_pair(8'h50, 8'h70, 1'b0);
    drive_pair(8'h51, 8'h71, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    bp_mode = 1'b1;
    check_line(make_line('{8'h50, 8'h51}, '{8'h70, 8'h71}), "bp_line");
    bp_mode = 1'b0;
    drive_pair(8'h52, 8'h72, 1'b0);
    drive_pair(8'h53, 8'h73, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    check_line(make_line('{8'h52, 8'h53}, '{8'h72, 8'h73}), "bp_after");

    // Reset in the third data bit of the second byte (0x32, bit2 = 0).
    drive_pair(8'h31, 8'h41, 1'b0);
    drive_pair(8'h32, 8'h42, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (53) @(negedge clk);
    check("rst_mid_tx_before", 32'(tx), 0);
    rst = 1'b1;
    #1;
    check("rst_mid_tx", 32'(tx), 1);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_overflow", 32'(overflow), 0);
    check("rst_mid_ready", 32'(in_ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive_pair(8'h7A, 8'h5A, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    check_line(make_line('{8'h7A}, '{8'h5A}), "post_rst");

    // Random lines with idle gaps; in_last during idle cycles must be ignored.
    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(1, DEP);
      l = {}; r = {};
      for (int i = 0; i < n; i++) begin
        a = 8'($urandom); c = 8'($urandom);
        gap = $urandom_range(0, 3);
        if (gap > 0) begin
          in_valid = 1'b0; in_last = 1'b1;
          repeat (gap) @(negedge clk);
        end
        l.push_back(a); r.push_back(c);
        drive_pair(a, c, i == n - 1);
      end
      in_valid = 1'b0; in_last = 1'b0;
      check_line(make_line(l, r), $sformatf("rnd%0d", t));
    end

    @(negedge clk);
    check("line_done_pulses", done_pulses, lines_expected);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
